sgen: RTL and testbench
=======================

SGEN -- requirements
Module: sgen

Interface
REQ-001 Parameter WIDTH, default 8, sets the pattern length in bits (legal range 2..32).
REQ-002 Parameter IDLE_LEVEL, default 1'b0, sets the line level on o when no bit is being sent.
REQ-003 Port ck  input  1  is the single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  is an asynchronous, active-high reset.
REQ-005 Port start  input  1  is a transfer request, sampled on the rising edge of ck.
REQ-006 Port pattern  input  WIDTH  is the bit pattern to transmit, MSB first.
REQ-007 Port o  output  1  is the serial output bit, suitable for driving sdet input i directly.
REQ-008 Port valid  output  1  is high in every cycle in which o carries a pattern bit (or the parity bit).
REQ-009 Port busy  output  1  is high from the cycle after start is accepted through the DONE cycle.
REQ-010 Port done  output  1  is a single-cycle pulse marking the end of a transfer.

Function
REQ-011 The FSM SHALL have these states: IDLE, SHIFT, PAR (only with SGEN_PARITY_EN), DONE.
REQ-012 In IDLE: o=IDLE_LEVEL, valid=0, busy=0, done=0.
REQ-013 In IDLE, start=1 at an edge SHALL capture pattern into the shift register, clear the bit counter and move to SHIFT.
REQ-014 A start accepted at edge N SHALL produce pattern[WIDTH-1] on o during cycle N+1, and bit k (MSB=0) during cycle N+1+k.
REQ-015 In SHIFT: o=shift-register MSB, valid=1, busy=1; each edge shifts left by one and increments the counter.
REQ-016 After the edge that completes bit WIDTH-1, the FSM SHALL go to PAR (macro defined) or DONE (macro undefined).
REQ-017 DONE SHALL last exactly one cycle: done=1, busy=1, valid=0, o=IDLE_LEVEL; the FSM then returns to IDLE.
REQ-018 start SHALL be ignored in SHIFT, PAR and DONE; held start re-triggers only when sampled in IDLE (minimum gap of 2 idle-level cycles between transfers).
REQ-019 Changes on pattern after capture SHALL NOT affect the transfer in progress.
REQ-020 o, valid, busy and done SHALL be glitch-free Moore outputs decoded from registered state only.

Reset
REQ-021 When reset asserts, state=IDLE, the shift register and counter clear, o=IDLE_LEVEL, and valid, busy and done are 0, immediately and without waiting for ck.
REQ-022 A reset during SHIFT or PAR SHALL abort the transfer with no done pulse; after deassertion the FSM waits in IDLE for a new start.

Configuration
REQ-023 When macro SGEN_PARITY_EN is defined, state PAR follows SHIFT for one cycle: o = odd-parity bit of the captured pattern (XNOR-reduce), valid=1.
REQ-024 When SGEN_PARITY_EN is undefined, PAR and its logic SHALL be absent, and a transfer SHALL be exactly WIDTH valid cycles.

Structure
REQ-025 Package sgen_pkg SHALL hold the state typedef (2-bit encoding IDLE=00, SHIFT=01, PAR=10, DONE=11) and the WIDTH range constants.
REQ-026 Sub-module sgen_shreg SHALL implement the loadable left-shift register (load, shift, msb out, parity out); the FSM and counter reside in sgen.

Verification
REQ-027 WIDTH=8, pattern=8'b1110_0000, start pulsed at edge 0 -> o=1,1,1,0,0,0,0,0 in cycles 1..8, valid=1 in cycles 1..8, done=1 in cycle 9 (no parity).
REQ-028 Loopback to sdet (o->i), pattern=8'b1110_0000 -> sdet o=1 sampled at the negedge after the third transmitted 1, and 0 after reset.
REQ-029 SGEN_PARITY_EN, pattern=8'hA5 -> bits 1,0,1,0,0,1,0,1 then parity bit 1 in cycle 9, done in cycle 10; pattern=8'hA4 -> parity bit 0.
REQ-030 Reset asserted mid-cycle after bit 3 -> o=IDLE_LEVEL and busy=0 before the next edge, no done pulse, and a new start afterwards sends the full pattern.
REQ-031 start held high continuously with pattern toggled during transfer -> each transfer sends the value captured at its start; start pulses during busy cause no extra transfer.

Source files
------------

// File: rtl/sgen_pkg.sv
// Shared definitions for the serial pattern generator: state encoding and
// the legal range of the WIDTH parameter.
package sgen_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // Sized so that the bit counter can reach WIDTH_MAX-1.
   localparam int CNT_W = $clog2(WIDTH_MAX);

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'b00;
   localparam state_t SHIFT = 2'b01;
   localparam state_t PAR   = 2'b10;
   localparam state_t DONE  = 2'b11;

endpackage

// File: rtl/sgen_shreg.sv
// Loadable left-shift register for sgen; with SGEN_PARITY_EN defined it also
// keeps the odd-parity bit of the value captured at load time.
module sgen_shreg
   import sgen_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
`ifdef SGEN_PARITY_EN
   output logic             parity,
`endif
   output logic             msb
);

   logic [WIDTH-1:0] sreg;

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= din;
      end else if (shift) begin
         sreg <= {sreg[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = sreg[WIDTH-1];

`ifdef SGEN_PARITY_EN
   // Parity is latched at load because the shift register contents change.
   logic par_q;

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         par_q <= 1'b0;
      end else if (load) begin
         par_q <= ~^din;
      end
   end

   assign parity = par_q;
`endif

endmodule

// File: rtl/sgen.sv
// Serial pattern generator: sends a WIDTH-bit pattern MSB first on o.
// Optional odd-parity trailer enabled by defining SGEN_PARITY_EN.
module sgen
   import sgen_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   output logic             o,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   generate
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
         $error("sgen: WIDTH out of range");
      end
   endgenerate

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             shift;
   logic             msb;
`ifdef SGEN_PARITY_EN
   logic             parity;
`endif

   assign load  = (state == IDLE) && start;
   assign shift = (state == SHIFT);

   sgen_shreg #(
      .WIDTH (WIDTH)
   ) u_shreg (
      .ck     (ck),
      .reset  (reset),
      .load   (load),
      .shift  (shift),
      .din    (pattern),
`ifdef SGEN_PARITY_EN
      .parity (parity),
`endif
      .msb    (msb)
   );

   // Start is only honoured in IDLE, so DONE plus IDLE always separate transfers.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SHIFT;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
`ifdef SGEN_PARITY_EN
                  state <= PAR;
`else
                  state <= DONE;
`endif
               end
            end
`ifdef SGEN_PARITY_EN
            PAR: begin
               state <= DONE;
            end
`endif
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o     = IDLE_LEVEL;
      valid = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         SHIFT: begin
            o     = msb;
            valid = 1'b1;
            busy  = 1'b1;
         end
`ifdef SGEN_PARITY_EN
         PAR: begin
            o     = parity;
            valid = 1'b1;
            busy  = 1'b1;
         end
`endif
         DONE: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: begin
            o = IDLE_LEVEL;
         end
      endcase
   end

endmodule

// File: tb/tb_sgen.sv
// Self-checking bench for sgen: table of patterns with expected parity,
// plus hand-written held-start and mid-transfer reset sequences.
module tb_sgen;

   localparam int   W        = 8;
   localparam logic IDLE_LVL = 1'b0;
`ifdef SGEN_PARITY_EN
   localparam int   NPAR     = 1;
`else
   localparam int   NPAR     = 0;
`endif
   localparam int   NB       = W + NPAR;

   typedef struct {
      string        name;
      logic [W-1:0] pat;
      logic         par;
   } vec_t;

   logic         ck = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] pattern = '0;
   logic         o;
   logic         valid;
   logic         busy;
   logic         done;

   int   n_checks = 0;
   int   n_fails  = 0;
   logic exp_q[$];
   vec_t vecs[6];

   sgen #(
      .WIDTH      (W),
      .IDLE_LEVEL (IDLE_LVL)
   ) dut (
      .ck      (ck),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .o       (o),
      .valid   (valid),
      .busy    (busy),
      .done    (done)
   );

   always #5 ck = ~ck;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic act, input logic expv);
      n_checks++;
      if (act !== expv) begin
         n_fails++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
      end
   endtask

   task automatic checkCount(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic pushPattern(input logic [W-1:0] p, input logic par);
      for (int k = W - 1; k >= 0; k--) exp_q.push_back(p[k]);
      if (NPAR == 1) exp_q.push_back(par);
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_o"}, o, IDLE_LVL);
      checkOutput({name, "_valid"}, valid, 1'b0);
      checkOutput({name, "_busy"}, busy, 1'b0);
      checkOutput({name, "_done"}, done, 1'b0);
   endtask

   task automatic checkBit(input string name);
      logic e;
      checkOutput({name, "_valid"}, valid, 1'b1);
      checkOutput({name, "_busy"}, busy, 1'b1);
      checkOutput({name, "_done"}, done, 1'b0);
      if (exp_q.size() == 0) begin
         checkCount({name, "_scoreboard_nonempty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         checkOutput({name, "_o"}, o, e);
      end
   endtask

   task automatic checkDone(input string name);
      checkOutput({name, "_done"}, done, 1'b1);
      checkOutput({name, "_busy"}, busy, 1'b1);
      checkOutput({name, "_valid"}, valid, 1'b0);
      checkOutput({name, "_o"}, o, IDLE_LVL);
   endtask

   // Called just after a negedge in IDLE; returns at the negedge of cycle 1.
   task automatic applyStimulus(input logic [W-1:0] p, input logic par);
      pattern = p;
      start   = 1'b1;
      pushPattern(p, par);
      @(negedge ck);
      start   = 1'b0;
      pattern = W'($urandom);
   endtask

   // Checks all bits, the DONE cycle and two idle cycles; pokes start while busy.
   task automatic checkTransfer(input string name);
      for (int c = 0; c < NB; c++) begin
         checkBit(name);
         pattern = W'($urandom);
         start   = (c == 2);
         @(negedge ck);
      end
      checkDone({name, "_donecyc"});
      start = 1'b1;
      @(negedge ck);
      start = 1'b0;
      checkIdle({name, "_gap1"});
      @(negedge ck);
      checkIdle({name, "_gap2"});
      checkCount({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      vec_t         v;
      logic [W-1:0] held[3];

      vecs[0] = '{"e0", 8'b1110_0000, 1'b0};
      vecs[1] = '{"a5", 8'hA5, 1'b1};
      vecs[2] = '{"a4", 8'hA4, 1'b0};
      vecs[3] = '{"ff", 8'hFF, 1'b1};
      vecs[4] = '{"01", 8'h01, 1'b0};
      vecs[5] = '{"80", 8'h80, 1'b0};

      #1 reset = 1'b1;
      #1 checkIdle("reset_async");
      @(negedge ck);
      checkIdle("reset_held");
      reset = 1'b0;
      @(negedge ck);
      checkIdle("post_reset");

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         applyStimulus(v.pat, v.par);
         checkTransfer(v.name);
      end

      // Start held high across three back-to-back transfers.
      held[0] = 8'h3C;
      held[1] = 8'hA5;
      held[2] = 8'h96;
      start   = 1'b1;
      pattern = held[0];
      pushPattern(held[0], ~^held[0]);
      for (int t = 0; t < 3; t++) begin
         for (int c = 0; c < NB; c++) begin
            @(negedge ck);
            checkBit("held");
            pattern = W'($urandom);
         end
         @(negedge ck);
         checkDone("held_done");
         @(negedge ck);
         checkIdle("held_gap");
         if (t < 2) begin
            pattern = held[t+1];
            pushPattern(held[t+1], ~^held[t+1]);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge ck);
      checkIdle("held_end");
      checkCount("held_queue_empty", exp_q.size(), 0);

      // Reset mid-cycle after bit 3 aborts the transfer without a done pulse.
      applyStimulus(8'hFF, 1'b1);
      for (int c = 0; c < 4; c++) begin
         checkBit("abort_pre");
         if (c < 3) @(negedge ck);
      end
      #2 reset = 1'b1;
      #1 checkIdle("abort_async");
      @(negedge ck);
      checkIdle("abort_in_reset");
      reset = 1'b0;
      exp_q.delete();
      @(negedge ck);
      checkIdle("abort_after1");
      @(negedge ck);
      checkIdle("abort_after2");
      applyStimulus(8'hC3, 1'b1);
      checkTransfer("abort_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
